pwm_multi_burst: RTL and testbench
==================================

Name: pwm_multi_burst

Overview:
Parametrised multi-channel PWM generator. This is the next generation of the single-channel period/duty/burst PWM. All channels share one period counter. Each channel has its own duty compare, enable and polarity. Period, duty and mode settings are double-buffered and take effect only on a period boundary, so changing them mid-period never produces glitches. It supports continuous, one-shot-burst and repeating-burst modes, and sits between the control registers and the gate-drive/LED output pins.

Parameters:
CHANNELS, 4, number of PWM outputs
PERIOD_W, 16, width of the period counter, duty and period values
BURST_W, 8, width of the burst pulse count

Ports:
sysclk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
period  input  PERIOD_W  PWM period in sysclk cycles
duty  input  CHANNELS*PERIOD_W  per-channel high time in cycles; channel i at [i*PERIOD_W +: PERIOD_W]
ch_en  input  CHANNELS  per-channel enable
ch_pol  input  CHANNELS  per-channel polarity; 1 inverts the active output
burstmode  input  1  0 = continuous, 1 = burst
bursttype  input  1  0 = one-shot burst on start, 1 = repeating burst
burst_len  input  BURST_W  number of periods per burst (and per gap)
start  input  1  one-cycle pulse that launches a one-shot burst
pwm  output  CHANNELS  PWM outputs, registered
period_tick  output  1  high on the last cycle of each active period
busy  output  1  high while in RUN or GAP
done  output  1  one-cycle pulse when a one-shot burst completes

Behaviour:
- Reset (sampled high on a sysclk edge):
  - cnt=0, burst counter=0, state=IDLE, all shadow registers=0.
  - pwm = ch_pol on every bit (inactive level). Outputs never glitch to the active level during reset.
  - period_tick=0, busy=0, done=0.
  - Asserting reset mid-operation aborts immediately; no done pulse is generated.
- Shadow load: period, duty, ch_en, ch_pol, burstmode, bursttype and burst_len are copied into shadows:
  - on every transition out of IDLE; and
  - on the cycle where cnt==Ps-1 (Ps = shadow period).
  - All other logic uses shadow values only.
- State machine:
  - IDLE:
    - burstmode=0, or burstmode=1 with bursttype=1 -> RUN on the next cycle.
    - burstmode=1 with bursttype=0 -> RUN on the cycle after start=1; otherwise stay in IDLE.
  - RUN:
    - cnt counts 0..Ps-1 and wraps. period_tick=1 when cnt==Ps-1.
    - Burst counter increments at each wrap when burstmode=1.
    - When burstmode=1 and the count reaches burst_len: one-shot -> IDLE with done=1 for one cycle; repeating -> GAP.
  - GAP:
    - cnt keeps running, pwm is held inactive, period_tick still pulses.
    - After burst_len periods -> RUN; the burst counter clears on each RUN/GAP transition.
  - Shadow burstmode=0 while in RUN: never leaves RUN.
  - Continuous mode ignores start.
- Output timing: pwm[i] is registered from cnt. It reflects the cnt value of the previous cycle: active = ch_en_s[i] && state==RUN && cnt < Ds[i]; pwm[i] = active XOR ch_pol_s[i].
- Boundaries:
  - Ds[i]=0 -> constant inactive.
  - Ds[i]>=Ps -> constant active for the whole period.
  - Ps=0 or Ps=1 -> cnt held at 0, pwm inactive, period_tick=0, state machine frozen. Recovery happens when a new period>=2 is applied: in IDLE it loads on the next exit; while frozen the shadow reloads every cycle.
  - burst_len=0 with burstmode=1 -> treated as 1.
  - start while busy -> ignored.
  - Simultaneous wrap and input change -> the new value takes effect from cnt=0 of the next period.
- Comparisons are unsigned and PERIOD_W wide; the counter never exceeds Ps-1.

Test Plan:
- Continuous mode: period=10, duty ch0=3, ch1=7, en=4'b0011, pol=0 -> ch0 high 3 / low 7, ch1 high 7 / low 3, repeating every 10 cycles; ch2 and ch3 stay low; period_tick once per 10 cycles.
- Duty change mid-period: change ch0 duty 3->8 at cnt=5 -> current period keeps 3 high cycles; next period has 8 high cycles; no runt pulse.
- One-shot burst: burstmode=1, bursttype=0, burst_len=3, period=20, duty=10 -> nothing before start; after start, exactly 3 pulses of 10 cycles; done pulses once; busy low afterwards; a second start repeats the burst.
- Repeating burst: bursttype=1, burst_len=2, period=8, duty=4 -> pattern of 2 pulses then 16 inactive cycles, repeating; period_tick continues during GAP.
- Boundaries: duty=0 gives constant inactive; duty=12 with period=10 gives constant active; ch_pol=1 inverts the output; period=1 gives inactive output with no ticks, and applying period=5 restores operation.
- Reset mid-burst (at cnt=4 of pulse 2): pwm goes to ch_pol, busy=0, no done pulse, state=IDLE; the next start produces a full 3-pulse burst.

Source files
------------

// File: rtl/pwm_multi_burst.sv
// Multi-channel PWM with a shared period counter, double-buffered settings
// and continuous / one-shot burst / repeating burst modes.
module pwm_multi_burst #(
    parameter int CHANNELS = 4,
    parameter int PERIOD_W = 16,
    parameter int BURST_W  = 8
) (
    input  logic                         sysclk,
    input  logic                         reset,
    input  logic [PERIOD_W-1:0]          period,
    input  logic [CHANNELS*PERIOD_W-1:0] duty,
    input  logic [CHANNELS-1:0]          ch_en,
    input  logic [CHANNELS-1:0]          ch_pol,
    input  logic                         burstmode,
    input  logic                         bursttype,
    input  logic [BURST_W-1:0]           burst_len,
    input  logic                         start,
    output logic [CHANNELS-1:0]          pwm,
    output logic                         period_tick,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                       state;
    logic [PERIOD_W-1:0]          cnt;
    logic [BURST_W-1:0]           bcnt;
    logic [PERIOD_W-1:0]          period_s;
    logic [CHANNELS*PERIOD_W-1:0] duty_s;
    logic [CHANNELS-1:0]          en_s;
    logic [CHANNELS-1:0]          pol_s;
    logic                         bm_s;
    logic                         bt_s;
    logic [BURST_W-1:0]           blen_s;

    logic                         frozen;
    logic                         wrap;
    logic                         launch;
    logic                         load_s;
    logic                         burst_end;
    logic [BURST_W-1:0]           blen_eff;
    logic [CHANNELS-1:0]          active;

    // Period values below 2 stall the counter; shadows keep reloading so a
    // valid period applied later takes over on the next cycle.
    always_comb begin
        frozen    = (period_s <= PERIOD_W'(1));
        wrap      = !frozen && (cnt == period_s - PERIOD_W'(1));
        launch    = burstmode ? (bursttype | start) : 1'b1;
        load_s    = (state == IDLE) ? launch : (frozen | wrap);
        blen_eff  = (blen_s == '0) ? BURST_W'(1) : blen_s;
        burst_end = ((bcnt + BURST_W'(1)) == blen_eff);
        active    = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            active[i] = en_s[i] && (state == RUN) && !frozen &&
                        (cnt < duty_s[i*PERIOD_W +: PERIOD_W]);
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bcnt        <= '0;
            period_s    <= '0;
            duty_s      <= '0;
            en_s        <= '0;
            pol_s       <= '0;
            bm_s        <= 1'b0;
            bt_s        <= 1'b0;
            blen_s      <= '0;
            pwm         <= ch_pol;
            period_tick <= 1'b0;
            done        <= 1'b0;
        end else begin
            done        <= 1'b0;
            period_tick <= wrap && (state != IDLE);
            // Shadow polarity is stale in IDLE, so the live one sets the idle level.
            pwm         <= active ^ ((state == IDLE) ? ch_pol : pol_s);

            if (load_s) begin
                period_s <= period;
                duty_s   <= duty;
                en_s     <= ch_en;
                pol_s    <= ch_pol;
                bm_s     <= burstmode;
                bt_s     <= bursttype;
                blen_s   <= burst_len;
            end

            case (state)
                IDLE: begin
                    cnt  <= '0;
                    bcnt <= '0;
                    if (launch) begin
                        state <= RUN;
                    end
                end
                RUN, GAP: begin
                    if (!frozen) begin
                        if (wrap) begin
                            cnt <= '0;
                            if (state == GAP) begin
                                if (!bm_s || burst_end) begin
                                    bcnt  <= '0;
                                    state <= RUN;
                                end else begin
                                    bcnt <= bcnt + BURST_W'(1);
                                end
                            end else if (bm_s) begin
                                if (burst_end) begin
                                    bcnt <= '0;
                                    if (bt_s) begin
                                        state <= GAP;
                                    end else begin
                                        state <= IDLE;
                                        done  <= 1'b1;
                                    end
                                end else begin
                                    bcnt <= bcnt + BURST_W'(1);
                                end
                            end
                        end else begin
                            cnt <= cnt + PERIOD_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_multi_burst.sv
// Testbench for pwm_multi_burst: table vectors, directed burst/boundary
// sequences and randomized traffic checked every cycle against a period-level model.
module tb_pwm_multi_burst;

    localparam int CH = 4;
    localparam int PW = 16;
    localparam int BW = 8;

    logic              sysclk = 1'b0;
    logic              reset;
    logic [PW-1:0]     period;
    logic [CH*PW-1:0]  duty;
    logic [CH-1:0]     ch_en;
    logic [CH-1:0]     ch_pol;
    logic              burstmode;
    logic              bursttype;
    logic [BW-1:0]     burst_len;
    logic              start;
    logic [CH-1:0]     pwm;
    logic              period_tick;
    logic              busy;
    logic              done;

    always #5 sysclk = ~sysclk;

    pwm_multi_burst #(
        .CHANNELS(CH),
        .PERIOD_W(PW),
        .BURST_W (BW)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .period     (period),
        .duty       (duty),
        .ch_en      (ch_en),
        .ch_pol     (ch_pol),
        .burstmode  (burstmode),
        .bursttype  (bursttype),
        .burst_len  (burst_len),
        .start      (start),
        .pwm        (pwm),
        .period_tick(period_tick),
        .busy       (busy),
        .done       (done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position within the period and the index of the
    // period since launch; RUN/GAP phase follows from period index arithmetic.
    typedef struct {
        int       per;
        int       d[CH];
        bit [3:0] en;
        bit [3:0] pol;
        bit       bm;
        bit       bt;
        int       bl;
    } cfg_t;

    cfg_t     cfg;
    bit       m_act;
    int       m_pos;
    int       m_pidx;
    bit [3:0] e_pwm;
    bit       e_tick, e_busy, e_done;

    function automatic cfg_t snap();
        cfg_t s;
        s.per = int'(period);
        for (int c = 0; c < CH; c++) s.d[c] = int'(duty[c*PW +: PW]);
        s.en  = ch_en;
        s.pol = ch_pol;
        s.bm  = burstmode;
        s.bt  = bursttype;
        s.bl  = int'(burst_len);
        return s;
    endfunction

    task automatic model_step();
        int blen;
        bit in_run;
        if (reset) begin
            e_pwm = ch_pol; e_tick = 0; e_busy = 0; e_done = 0;
            m_act = 0; m_pos = 0; m_pidx = 0;
            return;
        end
        e_tick = 0;
        e_done = 0;
        if (!m_act) begin
            e_pwm = ch_pol;
            if (!burstmode || bursttype || start) begin
                m_act = 1; cfg = snap(); m_pos = 0; m_pidx = 0;
            end
        end else if (cfg.per < 2) begin
            e_pwm = cfg.pol;
            cfg = snap();
        end else begin
            blen   = (cfg.bl == 0) ? 1 : cfg.bl;
            in_run = !cfg.bm || ((m_pidx % (2 * blen)) < blen);
            for (int c = 0; c < CH; c++)
                e_pwm[c] = (cfg.en[c] && in_run && (m_pos < cfg.d[c])) ^ cfg.pol[c];
            e_tick = (m_pos == cfg.per - 1);
            if (e_tick) begin
                m_pos = 0;
                m_pidx++;
                if (cfg.bm && !cfg.bt && m_pidx == blen) begin
                    m_act  = 0;
                    e_done = 1;
                end
                cfg = snap();
            end else begin
                m_pos++;
            end
        end
        e_busy = m_act;
    endtask

    task automatic cycle();
        @(posedge sysclk);
        model_step();
        @(negedge sysclk);
        check("pwm", pwm, e_pwm);
        check("period_tick", period_tick, e_tick);
        check("busy", busy, e_busy);
        check("done", done, e_done);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    task automatic set_duty(input int c, input int v);
        duty[c*PW +: PW] = PW'(v);
    endtask

    // Launches a one-shot burst and counts what comes out on channel 0.
    task automatic run_burst(input string tag, input int exp_pulses, input int exp_high);
        int rises, highs, dones;
        logic prev;
        rises = 0; highs = 0; dones = 0;
        prev  = pwm[0];
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 0; k < 90; k++) begin
            if (pwm[0] && !prev) rises++;
            highs += int'(pwm[0]);
            dones += int'(done);
            prev = pwm[0];
            cycle();
        end
        check({tag, "_pulses"}, rises, exp_pulses);
        check({tag, "_high"}, highs, exp_high);
        check({tag, "_done"}, dones, 1);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    typedef struct {
        int       per;
        int       d[CH];
        bit [3:0] en;
        bit [3:0] pol;
        int       win;
        int       hi[CH];
        int       ticks;
    } vec_t;

    vec_t vt[6];

    initial begin
        int hi[CH];
        int tk, h, rises;
        logic prev;
        bit found;

        vt[0] = '{per:10, d:'{3, 7, 5, 9},   en:4'b0011, pol:4'b0000, win:20, hi:'{6, 14, 0, 0},   ticks:2};
        vt[1] = '{per:10, d:'{0, 12, 10, 1}, en:4'b1111, pol:4'b0000, win:20, hi:'{0, 20, 20, 2},  ticks:2};
        vt[2] = '{per:10, d:'{3, 7, 5, 9},   en:4'b0011, pol:4'b1111, win:20, hi:'{14, 6, 20, 20}, ticks:2};
        vt[3] = '{per:1,  d:'{1, 3, 5, 9},   en:4'b1111, pol:4'b0000, win:20, hi:'{0, 0, 0, 0},    ticks:0};
        vt[4] = '{per:2,  d:'{1, 2, 0, 3},   en:4'b1111, pol:4'b0100, win:8,  hi:'{4, 8, 8, 8},    ticks:4};
        vt[5] = '{per:7,  d:'{6, 3, 7, 2},   en:4'b1010, pol:4'b0000, win:14, hi:'{0, 6, 0, 4},    ticks:2};

        reset = 1'b1; period = '0; duty = '0; ch_en = '0; ch_pol = '0;
        burstmode = 1'b0; bursttype = 1'b0; burst_len = '0; start = 1'b0;

        // Table-driven continuous-mode vectors
        for (int v = 0; v < 6; v++) begin
            period = PW'(vt[v].per);
            for (int c = 0; c < CH; c++) set_duty(c, vt[v].d[c]);
            ch_en = vt[v].en; ch_pol = vt[v].pol; burstmode = 1'b0;
            do_reset(2);
            check("reset_pwm", pwm, vt[v].pol);
            repeat (vt[v].per + 5) cycle();
            for (int c = 0; c < CH; c++) hi[c] = 0;
            tk = 0;
            for (int k = 0; k < vt[v].win; k++) begin
                cycle();
                for (int c = 0; c < CH; c++) hi[c] += int'(pwm[c]);
                tk += int'(period_tick);
            end
            for (int c = 0; c < CH; c++) check($sformatf("vec%0d_ch%0d_high", v, c), hi[c], vt[v].hi[c]);
            check($sformatf("vec%0d_ticks", v), tk, vt[v].ticks);
        end

        // Duty change in the middle of a period
        period = 16'd10; duty = '0; set_duty(0, 3); ch_en = 4'b0001; ch_pol = '0;
        do_reset(2);
        repeat (15) cycle();
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            found = period_tick;
        end
        check("dutychg_tick_seen", found, 1);
        h = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            h += int'(pwm[0]);
            if (k == 4) set_duty(0, 8);
        end
        check("dutychg_current_period", h, 3);
        h = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            h += int'(pwm[0]);
        end
        check("dutychg_next_period", h, 8);

        // One-shot burst
        burstmode = 1'b1; bursttype = 1'b0; burst_len = 8'd3;
        period = 16'd20; duty = '0; set_duty(0, 10); ch_en = 4'b0001; ch_pol = '0;
        do_reset(2);
        h = 0; tk = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            h  += int'(pwm[0]);
            tk += int'(busy);
        end
        check("oneshot_idle_high", h, 0);
        check("oneshot_idle_busy", tk, 0);
        run_burst("oneshot1", 3, 30);
        run_burst("oneshot2", 3, 30);

        // Repeating burst: 2 pulses then 2 silent periods
        bursttype = 1'b1; burst_len = 8'd2; period = 16'd8; duty = '0; set_duty(0, 4);
        do_reset(2);
        repeat (40) cycle();
        h = 0; tk = 0; rises = 0; prev = pwm[0];
        for (int k = 0; k < 64; k++) begin
            cycle();
            if (pwm[0] && !prev) rises++;
            h  += int'(pwm[0]);
            tk += int'(period_tick);
            prev = pwm[0];
        end
        check("repeat_high", h, 16);
        check("repeat_ticks", tk, 8);
        check("repeat_pulses", rises, 4);

        // Period 1 freezes; period 5 restores operation
        burstmode = 1'b0; bursttype = 1'b0; period = 16'd1; duty = '0; set_duty(0, 3);
        do_reset(2);
        h = 0; tk = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            h  += int'(pwm[0]);
            tk += int'(period_tick);
        end
        check("per1_high", h, 0);
        check("per1_ticks", tk, 0);
        period = 16'd5;
        repeat (10) cycle();
        h = 0; tk = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            h  += int'(pwm[0]);
            tk += int'(period_tick);
        end
        check("per5_high", h, 12);
        check("per5_ticks", tk, 4);

        // Reset in the middle of the second pulse of a one-shot burst
        burstmode = 1'b1; bursttype = 1'b0; burst_len = 8'd3; period = 16'd20;
        duty = '0; set_duty(0, 10); ch_en = 4'b0001; ch_pol = 4'b0010;
        do_reset(2);
        start = 1'b1;
        cycle();
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            cycle();
            found = m_act && (m_pidx == 1) && (m_pos == 4);
        end
        check("midreset_point_reached", found, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midreset_pwm", pwm, 4'b0010);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        tk = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            tk += int'(done) + int'(busy);
        end
        check("midreset_quiet", tk, 0);
        run_burst("after_reset", 3, 30);

        // Randomized traffic, mode fixed per segment
        for (int seg = 0; seg < 6; seg++) begin
            burstmode = (seg % 3) != 0;
            bursttype = (seg % 3) == 1;
            burst_len = BW'($urandom_range(0, 3));
            period    = PW'($urandom_range(2, 12));
            for (int c = 0; c < CH; c++) set_duty(c, int'($urandom_range(0, 14)));
            ch_en  = CH'($urandom);
            ch_pol = CH'($urandom);
            start  = 1'b0;
            do_reset(2);
            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 3))
                        0: period = PW'($urandom_range(0, 12));
                        1: set_duty(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 14)));
                        2: ch_en = CH'($urandom);
                        default: ch_pol = CH'($urandom);
                    endcase
                end
                start = ($urandom_range(0, 15) == 0);
                cycle();
            end
            start = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
